// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared types and helpers for the pipeline sequencing controller
package arm_pipe_pkg;

  // Program counter register; never a hazard or forwarding source
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  // One in-flight instruction as tracked by the scoreboard
  typedef struct packed {
    logic       valid;
    logic [3:0] wa3;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] ra3;
    logic [2:0] use_src;
  } sb_entry_t;

  // Register equality that ignores the PC
  function automatic logic reg_match(input logic [3:0] a, input logic [3:0] b);
    return (a == b) && (a != REG_PC);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - datapath/controller signal bundle for the hazard controller
interface pipe_hazard_ctrl_if;
  import arm_pipe_pkg::*;

  logic       validD;
  logic [3:0] RA1D;
  logic [3:0] RA2D;
  logic [3:0] RA3D;
  logic [2:0] useD;
  logic [3:0] WA3D;
  logic       RegWriteD;
  logic       MemToRegD;
  logic       MemWriteD;
  logic       PCSrcE;
  logic       mem_ready;

  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic       EnE;
  logic       EnM;
  logic       EnW;
  fwd_sel_t   FwdAE;
  fwd_sel_t   FwdBE;
  fwd_sel_t   FwdCE;
  logic       mem_err;

  // Datapath side: presents decode info, consumes pipeline controls
  modport master (
    output validD, RA1D, RA2D, RA3D, useD, WA3D,
    output RegWriteD, MemToRegD, MemWriteD, PCSrcE, mem_ready,
    input  StallF, StallD, FlushD, FlushE, EnE, EnM, EnW,
    input  FwdAE, FwdBE, FwdCE, mem_err
  );

  // Controller side
  modport slave (
    input  validD, RA1D, RA2D, RA3D, useD, WA3D,
    input  RegWriteD, MemToRegD, MemWriteD, PCSrcE, mem_ready,
    output StallF, StallD, FlushD, FlushE, EnE, EnM, EnW,
    output FwdAE, FwdBE, FwdCE, mem_err
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W shadow of in-flight instructions with hold and bubble insert
module hazard_scoreboard
  import arm_pipe_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  logic      bubble,
  input  sb_entry_t d_entry,
  output sb_entry_t e_entry,
  output sb_entry_t m_entry,
  output sb_entry_t w_entry
);

  sb_entry_t e_q, e_d;
  sb_entry_t m_q, m_d;
  sb_entry_t w_q, w_d;

  // Advance one stage per cycle unless frozen; E takes a bubble when flushed
  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (!hold) begin
      e_d = bubble ? sb_entry_t'('0) : d_entry;
      m_d = e_q;
      w_d = m_q;
    end
  end

  // Entry registers; reset empties the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign e_entry = e_q;
  assign m_entry = m_q;
  assign w_entry = w_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/enable and forwarding control for the five-stage pipeline
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int               CNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;

  sb_entry_t d_entry, e_entry, m_entry, w_entry;
  logic      ldstall;
  logic      mem_stall_m;
  logic      timeout_hit;
  logic      freeze;
  logic      flush_e_raw;

  // Select the youngest producer of src: ALU result in M first, then W result
  function automatic fwd_sel_t fwd_for(input logic [3:0] src, input logic used,
                                       input sb_entry_t m, input sb_entry_t w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (used && m.valid && m.regwrite && !m.memtoreg && reg_match(src, m.wa3))
      sel = FWD_MEM;
    else if (used && w.valid && w.regwrite && reg_match(src, w.wa3))
      sel = FWD_WB;
    return sel;
  endfunction

  // Pack the decode-stage instruction into a scoreboard entry
  always_comb begin
    d_entry          = '0;
    d_entry.valid    = bus.validD;
    d_entry.wa3      = bus.WA3D;
    d_entry.regwrite = bus.RegWriteD;
    d_entry.memtoreg = bus.MemToRegD;
    d_entry.memwrite = bus.MemWriteD;
    d_entry.ra1      = bus.RA1D;
    d_entry.ra2      = bus.RA2D;
    d_entry.ra3      = bus.RA3D;
    d_entry.use_src  = bus.useD;
  end

  hazard_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .hold    (freeze),
    .bubble  (flush_e_raw),
    .d_entry (d_entry),
    .e_entry (e_entry),
    .m_entry (m_entry),
    .w_entry (w_entry)
  );

  // Scoreboard fields that this controller never consults
  logic unused_sb_fields;
  assign unused_sb_fields = ^{e_entry.memwrite, m_entry.ra1, m_entry.ra2, m_entry.ra3,
                              m_entry.use_src, w_entry.memtoreg, w_entry.memwrite,
                              w_entry.ra1, w_entry.ra2, w_entry.ra3, w_entry.use_src};

  // Hazard conditions: load-use against E, memory stall in M, watchdog expiry
  always_comb begin
    ldstall = e_entry.valid && e_entry.memtoreg && e_entry.regwrite && bus.validD &&
              ((bus.useD[0] && reg_match(bus.RA1D, e_entry.wa3)) ||
               (bus.useD[1] && reg_match(bus.RA2D, e_entry.wa3)) ||
               (bus.useD[2] && reg_match(bus.RA3D, e_entry.wa3)));
    mem_stall_m = m_entry.valid && (m_entry.memtoreg || m_entry.memwrite) && !bus.mem_ready;
    timeout_hit = (cnt_q == CNT_MAX);
    // The watchdog cycle releases like a mem_ready cycle so the access drains
    freeze      = ((state_q == RUN) && mem_stall_m) ||
                  ((state_q == MEM_WAIT) && !bus.mem_ready && !timeout_hit);
    flush_e_raw = ldstall || bus.PCSrcE;
  end

  // Memory-wait FSM next state, watchdog counter and sticky error
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    case (state_q)
      RUN: begin
        if (mem_stall_m) begin
          state_d = MEM_WAIT;
          cnt_d   = '0;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d = RUN;
        end else if (timeout_hit) begin
          state_d   = RUN;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // FSM, counter and error flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Pipeline controls: freeze beats branch flush, branch flush beats load-use stall
  always_comb begin
    bus.StallF  = 1'b0;
    bus.StallD  = 1'b0;
    bus.FlushD  = 1'b0;
    bus.FlushE  = 1'b0;
    bus.EnE     = 1'b1;
    bus.EnM     = 1'b1;
    bus.EnW     = 1'b1;
    bus.FwdAE   = FWD_RF;
    bus.FwdBE   = FWD_RF;
    bus.FwdCE   = FWD_RF;
    bus.mem_err = mem_err_q && !rst;
    if (!rst) begin
      bus.FwdAE = fwd_for(e_entry.ra1, e_entry.use_src[0], m_entry, w_entry);
      bus.FwdBE = fwd_for(e_entry.ra2, e_entry.use_src[1], m_entry, w_entry);
      bus.FwdCE = fwd_for(e_entry.ra3, e_entry.use_src[2], m_entry, w_entry);
      if (freeze) begin
        bus.StallF = 1'b1;
        bus.StallD = 1'b1;
        bus.EnE    = 1'b0;
        bus.EnM    = 1'b0;
        bus.EnW    = 1'b0;
      end else begin
        bus.StallF = ldstall && !bus.PCSrcE;
        bus.StallD = ldstall && !bus.PCSrcE;
        bus.FlushD = bus.PCSrcE;
        bus.FlushE = flush_e_raw;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import arm_pipe_pkg::*;

  // {StallF, StallD, FlushD, FlushE, EnE, EnM, EnW, mem_err}
  localparam logic [7:0] CTL_IDLE = 8'b0000_1110;
  localparam logic [7:0] CTL_LDST = 8'b1101_1110;
  localparam logic [7:0] CTL_BR   = 8'b0011_1110;
  localparam logic [7:0] CTL_FRZ  = 8'b1100_0000;
  localparam logic [7:0] CTL_ERR  = 8'b0000_1111;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire [7:0] ctl = {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE,
                    bus.EnE, bus.EnM, bus.EnW, bus.mem_err};
  wire [5:0] fwd = {bus.FwdAE, bus.FwdBE, bus.FwdCE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_d(input logic v, input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic [3:0] ra3, input logic [2:0] u, input logic [3:0] wa3,
                       input logic rw, input logic m2r, input logic mw);
    bus.validD    = v;
    bus.RA1D      = ra1;
    bus.RA2D      = ra2;
    bus.RA3D      = ra3;
    bus.useD      = u;
    bus.WA3D      = wa3;
    bus.RegWriteD = rw;
    bus.MemToRegD = m2r;
    bus.MemWriteD = mw;
  endtask

  task automatic set_nop();
    set_d(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.PCSrcE    = 1'b0;
    bus.mem_ready = 1'b1;
    set_nop();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.PCSrcE    = 1'b1;
    bus.mem_ready = 1'b0;
    set_d(1'b1, 4'd2, 4'd2, 4'd2, 3'b111, 4'd2, 1'b1, 1'b1, 1'b0);
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_IDLE); end
    checks++;
    if (fwd !== 6'b000000) begin errors++; $display("FAIL reset_fwd: got %b expected %b", fwd, 6'b000000); end
    set_nop();
    bus.PCSrcE    = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL post_reset_ctl: got %b expected %b", ctl, CTL_IDLE); end
    checks++;
    if (fwd !== 6'b000000) begin errors++; $display("FAIL post_reset_fwd: got %b expected %b", fwd, 6'b000000); end
    tick();
  endtask

  task automatic test_forward();
    do_reset();
    set_d(1'b1, 4'd1, 4'd2, 4'd0, 3'b011, 4'd3, 1'b1, 1'b0, 1'b0);  // ADD r3,r1,r2
    settle(); tick();
    set_d(1'b1, 4'd3, 4'd4, 4'd0, 3'b011, 4'd5, 1'b1, 1'b0, 1'b0);  // SUB r5,r3,r4
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL fwd_no_stall: got %b expected %b", ctl, CTL_IDLE); end
    tick();
    set_d(1'b1, 4'd6, 4'd3, 4'd0, 3'b011, 4'd6, 1'b1, 1'b0, 1'b0);  // ORR r6,r6,r3
    settle();
    checks++;
    if (fwd !== 6'b10_00_00) begin errors++; $display("FAIL fwd_m_a: got %b expected %b", fwd, 6'b10_00_00); end
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL fwd_m_ctl: got %b expected %b", ctl, CTL_IDLE); end
    tick();
    set_nop();
    settle();
    checks++;
    if (fwd !== 6'b00_01_00) begin errors++; $display("FAIL fwd_w_b: got %b expected %b", fwd, 6'b00_01_00); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd2, 1'b1, 1'b1, 1'b0);  // LDR r2,[r1]
    settle(); tick();
    set_d(1'b1, 4'd2, 4'd1, 4'd0, 3'b011, 4'd4, 1'b1, 1'b0, 1'b0);  // ADD r4,r2,r1
    settle();
    checks++;
    if (ctl !== CTL_LDST) begin errors++; $display("FAIL lu_stall: got %b expected %b", ctl, CTL_LDST); end
    tick();
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL lu_single_bubble: got %b expected %b", ctl, CTL_IDLE); end
    checks++;
    if (fwd !== 6'b000000) begin errors++; $display("FAIL lu_bubble_fwd: got %b expected %b", fwd, 6'b000000); end
    tick();
    set_nop();
    settle();
    checks++;
    if (fwd !== 6'b01_00_00) begin errors++; $display("FAIL lu_fwd_w: got %b expected %b", fwd, 6'b01_00_00); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    set_d(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd2, 1'b1, 1'b1, 1'b0);  // LDR r2,[r1]
    settle(); tick();
    set_d(1'b1, 4'd2, 4'd1, 4'd0, 3'b011, 4'd4, 1'b1, 1'b0, 1'b0);  // dependent ADD
    bus.PCSrcE = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_BR) begin errors++; $display("FAIL br_over_ldstall: got %b expected %b", ctl, CTL_BR); end
    tick();
    bus.PCSrcE = 1'b0;
    set_d(1'b1, 4'd6, 4'd0, 4'd0, 3'b001, 4'd7, 1'b1, 1'b0, 1'b0);  // target: r7 <- r6
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL br_after: got %b expected %b", ctl, CTL_IDLE); end
    tick();
    set_d(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd6, 1'b1, 1'b0, 1'b0);  // ADD r6 on wrong path
    bus.PCSrcE = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_BR) begin errors++; $display("FAIL br_plain: got %b expected %b", ctl, CTL_BR); end
    tick();
    bus.PCSrcE = 1'b0;
    set_d(1'b1, 4'd6, 4'd0, 4'd0, 3'b001, 4'd8, 1'b1, 1'b0, 1'b0);  // reads r6
    settle(); tick();
    set_nop();
    settle();
    checks++;
    if (fwd !== 6'b000000) begin errors++; $display("FAIL br_squashed_fwd: got %b expected %b", fwd, 6'b000000); end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_d(1'b1, 4'd1, 4'd2, 4'd0, 3'b011, 4'd0, 1'b0, 1'b0, 1'b1);  // STR
    settle(); tick();
    set_d(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd8, 1'b1, 1'b0, 1'b0);  // ADD r8
    settle(); tick();
    set_d(1'b1, 4'd8, 4'd0, 4'd0, 3'b001, 4'd9, 1'b1, 1'b0, 1'b0);  // SUB r9,r8
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.PCSrcE = (i == 1);
      settle();
      checks++;
      if (ctl !== CTL_FRZ) begin errors++; $display("FAIL mw_freeze[%0d]: got %b expected %b", i, ctl, CTL_FRZ); end
      tick();
    end
    bus.PCSrcE    = 1'b0;
    bus.mem_ready = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL mw_release: got %b expected %b", ctl, CTL_IDLE); end
    tick();
    set_nop();
    settle();
    checks++;
    if (fwd !== 6'b10_00_00) begin errors++; $display("FAIL mw_held_fwd: got %b expected %b", fwd, 6'b10_00_00); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    set_d(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd9, 1'b1, 1'b1, 1'b0);  // LDR r9
    settle(); tick();
    set_nop();
    settle(); tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (ctl !== CTL_FRZ) begin errors++; $display("FAIL to_freeze[%0d]: got %b expected %b", i, ctl, CTL_FRZ); end
      tick();
    end
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL to_release: got %b expected %b", ctl, CTL_IDLE); end
    tick();
    settle();
    checks++;
    if (ctl !== CTL_ERR) begin errors++; $display("FAIL to_err_set: got %b expected %b", ctl, CTL_ERR); end
    tick();
    settle();
    checks++;
    if (ctl !== CTL_ERR) begin errors++; $display("FAIL to_err_sticky: got %b expected %b", ctl, CTL_ERR); end
    tick();
    rst = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL to_rst_out: got %b expected %b", ctl, CTL_IDLE); end
    tick();
    rst           = 1'b0;
    bus.mem_ready = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL to_rst_clear: got %b expected %b", ctl, CTL_IDLE); end
    tick();
  endtask

  task automatic test_r15();
    do_reset();
    set_d(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd15, 1'b1, 1'b1, 1'b0);    // LDR r15
    settle(); tick();
    set_d(1'b1, 4'd15, 4'd15, 4'd15, 3'b111, 4'd1, 1'b1, 1'b0, 1'b0);  // reads r15 x3
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL r15_no_stall: got %b expected %b", ctl, CTL_IDLE); end
    tick();
    set_d(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd15, 1'b1, 1'b0, 1'b0);    // ALU write r15
    settle(); tick();
    set_d(1'b1, 4'd15, 4'd15, 4'd15, 3'b111, 4'd2, 1'b1, 1'b0, 1'b0);
    settle(); tick();
    set_nop();
    settle();
    checks++;
    if (fwd !== 6'b000000) begin errors++; $display("FAIL r15_no_fwd: got %b expected %b", fwd, 6'b000000); end
    tick();
  endtask

  task automatic test_use_mask();
    do_reset();
    set_d(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd5, 1'b1, 1'b1, 1'b0);  // LDR r5
    settle(); tick();
    set_d(1'b1, 4'd0, 4'd5, 4'd0, 3'b001, 4'd6, 1'b1, 1'b0, 1'b0);  // r5 on B but B unused
    settle();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL use_mask_b: got %b expected %b", ctl, CTL_IDLE); end
    tick();
    set_d(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd5, 1'b1, 1'b1, 1'b0);  // LDR r5
    settle(); tick();
    set_d(1'b1, 4'd0, 4'd0, 4'd5, 3'b100, 4'd7, 1'b1, 1'b0, 1'b0);  // r5 as C
    settle();
    checks++;
    if (ctl !== CTL_LDST) begin errors++; $display("FAIL use_c_stall: got %b expected %b", ctl, CTL_LDST); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_d(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd7, 1'b1, 1'b0, 1'b0);  // r7 <- imm
    settle(); tick();
    set_d(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd7, 1'b1, 1'b0, 1'b0);  // r7 <- r1
    settle(); tick();
    set_d(1'b1, 4'd0, 4'd0, 4'd7, 3'b100, 4'd8, 1'b1, 1'b0, 1'b0);  // reads r7 as C
    settle(); tick();
    set_nop();
    settle();
    checks++;
    if (fwd !== 6'b00_00_10) begin errors++; $display("FAIL b2b_m_over_w: got %b expected %b", fwd, 6'b00_00_10); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_r15();
    test_use_mask();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
